// File: rtl/wb_pkg.sv
// wb_pkg: writeback source encodings, entry layout and the source-select function
package wb_pkg;
    localparam int WB_XLEN = 32;
    localparam int WB_RAW = 5;
    typedef enum logic [2:0] {
        WB_ALU   = 3'b000,
        WB_LINK  = 3'b001,
        WB_PCREL = 3'b010,
        WB_MEM   = 3'b011,
        WB_IMM   = 3'b100,
        WB_ZERO  = 3'b101
    } wb_sel_t;
    typedef struct packed {
        logic [WB_XLEN-1:0] data;
        logic [WB_RAW-1:0]  rd;
        logic               we;
    } wb_entry_t;
    function automatic logic sel_legal(input wb_sel_t s);
        return !(s[2] & s[1]);
    endfunction
    function automatic logic [WB_XLEN-1:0] wb_select(
        input wb_sel_t s,
        input logic [WB_XLEN-1:0] alu, link, rel, mem, imm
    );
        return s == WB_ALU   ? alu  :
               s == WB_LINK  ? link :
               s == WB_PCREL ? rel  :
               s == WB_MEM   ? mem  :
               s == WB_IMM   ? imm  : '0;
    endfunction
endpackage

// File: rtl/wb_skid_buf.sv
// wb_skid_buf: two-entry elastic buffer (main + skid) with flush, in-order output
module wb_skid_buf #(
    parameter int W = 38
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);
    logic         s_valid;
    logic [W-1:0] s_data;
    logic         acc;
    assign in_ready = !s_valid & !reset;
    assign acc = in_valid & in_ready & !flush;
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            s_valid   <= 1'b0;
            s_data    <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
            s_valid   <= 1'b0;
        end else if (!out_valid || out_ready) begin
            out_valid <= s_valid | acc;
            s_valid   <= 1'b0;
            if (s_valid) out_data <= s_data;
            else if (acc) out_data <= in_data;
        end else if (acc) begin
            s_valid <= 1'b1;
            s_data  <= in_data;
        end
    end
endmodule

// File: rtl/wb_select_stage.sv
// wb_select_stage: registered writeback-result selector with skid buffer and forwarding tap
module wb_select_stage
    import wb_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int PCW  = 9,
    parameter int RAW  = 5
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      in_sel,
    input  logic [PCW-1:0]  in_pc_link,
    input  logic [PCW-1:0]  in_pc_rel,
    input  logic [XLEN-1:0] in_alu,
    input  logic [XLEN-1:0] in_mem,
    input  logic [XLEN-1:0] in_imm,
    input  logic [RAW-1:0]  in_rd,
    input  logic            in_we,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_data,
    output logic [RAW-1:0]  out_rd,
    output logic            out_we,
    output logic            fwd_valid,
    output logic [RAW-1:0]  fwd_rd,
    output logic [XLEN-1:0] fwd_data,
    output logic            err_illegal
);
    localparam int W = XLEN + RAW + 1;
    wb_sel_t       sel;
    logic          legal;
    logic          acc;
    logic [XLEN-1:0] data;
    logic [W-1:0]  q;
    assign sel = wb_sel_t'(in_sel);
    assign legal = sel_legal(sel);
    assign data = XLEN'(wb_select(sel, WB_XLEN'(in_alu), WB_XLEN'(in_pc_link),
                                  WB_XLEN'(in_pc_rel), WB_XLEN'(in_mem), WB_XLEN'(in_imm)));
    assign acc = in_valid & in_ready & !flush;
    wb_skid_buf #(.W(W)) u_buf (
        .clk(clk),
        .reset(reset),
        .flush(flush),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_data({data, in_rd, in_we & (|in_rd) & legal}),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(q)
    );
    assign {out_data, out_rd, out_we} = q;
    assign fwd_valid = out_valid & out_we;
    assign fwd_rd = out_rd;
    assign fwd_data = out_data;
    always_ff @(posedge clk) begin
        if (reset) err_illegal <= 1'b0;
        else if (acc && !legal) err_illegal <= 1'b1;
    end
endmodule

// File: tb/tb_wb_select_stage.sv
// tb_wb_select_stage: directed plan checks plus randomized traffic against a queue model
module tb_wb_select_stage;
    logic        clk = 1'b0;
    logic        reset, flush, in_valid, in_we, out_ready;
    logic [2:0]  in_sel;
    logic [8:0]  in_pc_link, in_pc_rel;
    logic [31:0] in_alu, in_mem, in_imm;
    logic [4:0]  in_rd;
    logic        in_ready, out_valid, out_we, fwd_valid, err_illegal;
    logic [31:0] out_data, fwd_data;
    logic [4:0]  out_rd, fwd_rd;

    typedef struct {
        logic [31:0] d;
        logic [4:0]  rd;
        logic        we;
    } ent_t;
    ent_t q[$];
    logic err_m;
    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    wb_select_stage dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_sel(in_sel),
        .in_pc_link(in_pc_link), .in_pc_rel(in_pc_rel),
        .in_alu(in_alu), .in_mem(in_mem), .in_imm(in_imm),
        .in_rd(in_rd), .in_we(in_we),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_rd(out_rd), .out_we(out_we),
        .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
        .err_illegal(err_illegal)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic ent_t ref_ent();
        ent_t e;
        case (in_sel)
            3'd0: e.d = in_alu;
            3'd1: e.d = {23'd0, in_pc_link};
            3'd2: e.d = {23'd0, in_pc_rel};
            3'd3: e.d = in_mem;
            3'd4: e.d = in_imm;
            default: e.d = 32'd0;
        endcase
        e.rd = in_rd;
        e.we = in_we && in_rd != 0 && in_sel < 6;
        return e;
    endfunction

    task automatic check_all();
        chk("in_ready", in_ready, !reset && q.size() < 2);
        chk("out_valid", out_valid, q.size() > 0);
        chk("err_illegal", err_illegal, err_m);
        if (q.size() > 0) begin
            chk("out_data", out_data, q[0].d);
            chk("out_rd", out_rd, q[0].rd);
            chk("out_we", out_we, q[0].we);
            chk("fwd_valid", fwd_valid, q[0].we);
            chk("fwd_data", fwd_data, q[0].d);
            chk("fwd_rd", fwd_rd, q[0].rd);
        end else begin
            chk("fwd_valid_idle", fwd_valid, 0);
        end
    endtask

    task automatic tick();
        bit acc;
        #1 check_all();
        @(posedge clk);
        if (reset) begin
            q.delete();
            err_m = 1'b0;
        end else if (flush) begin
            q.delete();
        end else begin
            acc = in_valid && q.size() < 2;
            if (out_ready && q.size() > 0) void'(q.pop_front());
            if (acc) q.push_back(ref_ent());
            if (acc && in_sel >= 6) err_m = 1'b1;
        end
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input logic [2:0] s, input logic [31:0] alu,
                         input logic [4:0] rd, input logic we, input logic ordy);
        in_valid = v; in_sel = s; in_alu = alu; in_rd = rd; in_we = we; out_ready = ordy;
    endtask

    initial begin
        reset = 1; flush = 0; err_m = 0;
        drive(0, 3'd0, 32'd0, 5'd0, 0, 0);
        in_pc_link = 0; in_pc_rel = 0; in_mem = 0; in_imm = 0;
        @(posedge clk); @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_rd", out_rd, 0);
        chk("rst_out_we", out_we, 0);
        chk("rst_err", err_illegal, 0);
        chk("rst_in_ready", in_ready, 0);
        reset = 0;
        #1 chk("post_rst_in_ready", in_ready, 1);

        // link address zero-extended
        drive(1, 3'd1, 32'd0, 5'd1, 1, 1); in_pc_link = 9'h1F4;
        tick();
        chk("t1_data", out_data, 32'h000001F4);
        chk("t1_we", out_we, 1);
        chk("t1_fwd", fwd_valid, 1);
        // rd=0 suppresses write
        drive(1, 3'd0, 32'hDEADBEEF, 5'd0, 1, 1);
        tick();
        chk("t2_data", out_data, 32'hDEADBEEF);
        chk("t2_we", out_we, 0);
        chk("t2_fwd", fwd_valid, 0);
        drive(0, 3'd0, 32'd0, 5'd0, 0, 1);
        tick();
        // backpressure and ordering
        drive(1, 3'd0, 32'd1, 5'd3, 1, 0);
        tick();
        drive(1, 3'd0, 32'd2, 5'd4, 1, 0);
        tick();
        chk("t3_full_ready", in_ready, 0);
        drive(0, 3'd0, 32'd0, 5'd0, 0, 1);
        chk("t3_first", out_data, 32'd1);
        tick();
        chk("t3_second", out_data, 32'd2);
        tick();
        chk("t3_ready_back", in_ready, 1);
        chk("t3_empty", out_valid, 0);
        // flush while full
        drive(1, 3'd0, 32'd7, 5'd5, 1, 0);
        tick();
        drive(1, 3'd0, 32'd8, 5'd6, 1, 0);
        tick();
        drive(1, 3'd0, 32'd9, 5'd7, 1, 1); flush = 1;
        tick();
        flush = 0; drive(0, 3'd0, 32'd0, 5'd0, 0, 1);
        chk("t4_valid", out_valid, 0);
        chk("t4_ready", in_ready, 1);
        tick();
        // illegal select
        drive(1, 3'd7, 32'h12345678, 5'd5, 1, 1);
        tick();
        chk("t5_data", out_data, 0);
        chk("t5_we", out_we, 0);
        chk("t5_err", err_illegal, 1);
        drive(0, 3'd0, 32'd0, 5'd0, 0, 1);
        tick(); tick();
        chk("t5_err_hold", err_illegal, 1);
        // reset with an entry held
        drive(1, 3'd0, 32'hCAFEF00D, 5'd9, 1, 0);
        tick();
        drive(0, 3'd0, 32'd0, 5'd0, 0, 0); reset = 1;
        #1 chk("t6_ready_in_rst", in_ready, 0);
        tick();
        chk("t6_valid", out_valid, 0);
        chk("t6_data", out_data, 0);
        chk("t6_err", err_illegal, 0);
        reset = 0;
        #1 chk("t6_ready_after", in_ready, 1);

        for (int i = 0; i < 600; i++) begin
            in_valid = $urandom_range(0, 3) != 0;
            in_sel = 3'($urandom_range(0, 7));
            in_pc_link = 9'($urandom);
            in_pc_rel = 9'($urandom);
            in_alu = $urandom;
            in_mem = $urandom;
            in_imm = $urandom;
            in_rd = $urandom_range(0, 3) == 0 ? 5'd0 : 5'($urandom);
            in_we = $urandom_range(0, 1) == 1;
            out_ready = $urandom_range(0, 2) != 0;
            flush = $urandom_range(0, 15) == 0;
            reset = $urandom_range(0, 63) == 0;
            tick();
        end
        reset = 0; flush = 0; in_valid = 0;
        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
